// File: rtl/alu_seq16_pkg.sv
// Shared definitions: the ALU control encodings and the sequencer's op/state types.
// The optional HI->DONE skip in alu_seq16 is enabled by ALU_SEQ_SKIP_EN.
package ALU_def;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_LT  = 3'd4
  } ALU_CTRL;
endpackage

package alu_seq_def;
  import ALU_def::*;

  typedef enum logic [1:0] {
    SEQ_ADD = 2'd0,
    SEQ_SUB = 2'd1,
    SEQ_AND = 2'd2,
    SEQ_OR  = 2'd3
  } SEQ_OP;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    CY   = 3'd2,
    HI   = 3'd3,
    HC   = 3'd4,
    DONE = 3'd5
  } SEQ_STATE;

  // ALU operation used for the byte passes (LO, HI and HC) of a given op.
  function automatic ALU_CTRL seq_byte_ctrl(input SEQ_OP op);
    case (op)
      SEQ_ADD: seq_byte_ctrl = ALU_ADD;
      SEQ_SUB: seq_byte_ctrl = ALU_SUB;
      SEQ_AND: seq_byte_ctrl = ALU_AND;
      default: seq_byte_ctrl = ALU_OR;
    endcase
  endfunction
endpackage

// File: rtl/alu_seq16.sv
// 16-bit ADD/SUB/AND/OR sequencer that drives an external 8-bit ALU byte by byte.
// Define ALU_SEQ_SKIP_EN to bypass the HC pass when no carry/borrow was produced.
module alu_seq16
  import ALU_def::*;
  import alu_seq_def::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  SEQ_OP       req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_zero,
  output ALU_CTRL     alu_ctrl,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_out
);

  SEQ_STATE    r_state, w_state_nxt;
  SEQ_OP       r_op;
  logic [15:0] r_a, r_b, r_res;
  logic        r_cy;
  logic        w_arith;

  assign w_arith = (r_op == SEQ_ADD) || (r_op == SEQ_SUB);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= SEQ_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (req_valid) begin
          r_op <= req_op;
          r_a  <= req_a;
          r_b  <= req_b;
          r_cy <= 1'b0;
        end
        LO:      r_res[7:0]  <= alu_out;
        CY:      r_cy        <= alu_out[0];
        HI:      r_res[15:8] <= alu_out;
        HC:      r_res[15:8] <= alu_out;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    alu_ctrl    = ALU_AND;
    alu_a       = '0;
    alu_b       = '0;
    case (r_state)
      IDLE: if (req_valid) w_state_nxt = LO;
      LO: begin
        alu_ctrl    = seq_byte_ctrl(r_op);
        alu_a       = r_a[7:0];
        alu_b       = r_b[7:0];
        w_state_nxt = w_arith ? CY : HI;
      end
      CY: begin
        // The ALU has no carry-out: ADD carry is (sum < A), SUB borrow is (A < B).
        alu_ctrl = ALU_LT;
        if (r_op == SEQ_ADD) begin
          alu_a = r_res[7:0];
          alu_b = r_a[7:0];
        end else begin
          alu_a = r_a[7:0];
          alu_b = r_b[7:0];
        end
        w_state_nxt = HI;
      end
      HI: begin
        alu_ctrl = seq_byte_ctrl(r_op);
        alu_a    = r_a[15:8];
        alu_b    = r_b[15:8];
`ifdef ALU_SEQ_SKIP_EN
        w_state_nxt = (w_arith && r_cy) ? HC : DONE;
`else
        w_state_nxt = w_arith ? HC : DONE;
`endif
      end
      HC: begin
        alu_ctrl    = seq_byte_ctrl(r_op);
        alu_a       = r_res[15:8];
        alu_b       = {7'b0, r_cy};
        w_state_nxt = DONE;
      end
      DONE: if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == DONE);
  assign rsp_result = r_res;
  assign rsp_zero   = (r_res == 16'h0000);

endmodule

// File: tb/tb_alu_seq16.sv
// Self-checking bench for alu_seq16: directed plus random ops against an arithmetic model.
// Expected latency follows ALU_SEQ_SKIP_EN when the bench is built with it.
module tb_alu_seq16;
  import ALU_def::*;
  import alu_seq_def::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  SEQ_OP       req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  ALU_CTRL     alu_ctrl;
  logic [7:0]  alu_a, alu_b, alu_out;

  int checks   = 0;
  int failures = 0;

  ALU_CTRL    ctrl_q[$];
  logic [7:0] b_q[$];

  always #5 clk = ~clk;

  alu_seq16 dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  // Stand-in for the shared 8-bit ALU owned by the parent.
  always_comb begin
    alu_out = 8'h00;
    case (alu_ctrl)
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_LT:  alu_out = {7'b0, (alu_a < alu_b)};
      default: alu_out = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_result(input SEQ_OP op, input logic [15:0] a, b);
    int unsigned r;
    case (op)
      SEQ_ADD: r = (int'(a) + int'(b)) % 65536;
      SEQ_SUB: r = (int'(a) - int'(b) + 65536) % 65536;
      SEQ_AND: r = a & b;
      default: r = a | b;
    endcase
    return r[15:0];
  endfunction

  function automatic int model_latency(input SEQ_OP op, input logic [15:0] a, b);
    bit carry;
    if (op == SEQ_AND || op == SEQ_OR) return 3;
    if (op == SEQ_ADD) carry = (int'(a[7:0]) + int'(b[7:0])) > 255;
    else               carry = a[7:0] < b[7:0];
`ifdef ALU_SEQ_SKIP_EN
    return carry ? 5 : 4;
`else
    return carry ? 5 : 5;
`endif
  endfunction

  // One full transaction; hold = cycles rsp_ready is kept low after rsp_valid rises.
  task automatic do_op(input SEQ_OP op, input logic [15:0] a, b, input int hold);
    logic [15:0] exp;
    int lat;
    exp = model_result(op, a, b);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom);
    ctrl_q.delete(); b_q.delete();
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      ctrl_q.push_back(alu_ctrl);
      b_q.push_back(alu_b);
      @(posedge clk);
      lat++;
    end
    chk("latency", lat, model_latency(op, a, b));
    chk("result", rsp_result, exp);
    chk("zero", rsp_zero, exp == 16'h0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, exp);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = SEQ_ADD;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_zero", rsp_zero, 1);
    chk("rst_ctrl", alu_ctrl, ALU_AND);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    reset = 1'b0;

    // Carry from the low byte: ADD, LT, ADD, ADD.
    do_op(SEQ_ADD, 16'h12FF, 16'h0001, 0);
    chk("add_seq_len", ctrl_q.size(), 4);
    chk("add_seq0", ctrl_q[0], ALU_ADD);
    chk("add_seq1", ctrl_q[1], ALU_LT);
    chk("add_seq2", ctrl_q[2], ALU_ADD);
    chk("add_seq3", ctrl_q[3], ALU_ADD);

    // Borrow from the low byte: HC subtracts 1.
    do_op(SEQ_SUB, 16'h1000, 16'h0001, 0);
    chk("sub_hc_ctrl", ctrl_q[3], ALU_SUB);
    chk("sub_hc_b", b_q[3], 8'h01);

    do_op(SEQ_ADD, 16'hFFFF, 16'h0001, 1);

    do_op(SEQ_AND, 16'hF0F0, 16'h3C3C, 0);
    chk("and_seq_len", ctrl_q.size(), 2);
    chk("and_seq0", ctrl_q[0], ALU_AND);
    chk("and_seq1", ctrl_q[1], ALU_AND);
    do_op(SEQ_OR, 16'h00F0, 16'h0F00, 0);
    chk("or_seq_len", ctrl_q.size(), 2);
    chk("or_seq1", ctrl_q[1], ALU_OR);

    // Long backpressure.
    do_op(SEQ_SUB, 16'h0000, 16'h0001, 10);

    // Skip-path candidates (latency depends on build).
    do_op(SEQ_ADD, 16'h0101, 16'h0101, 0);
    do_op(SEQ_ADD, 16'h00FF, 16'h0001, 0);
    do_op(SEQ_SUB, 16'h5555, 16'h1111, 0);

    // Reset during HI abandons the op.
    @(negedge clk);
    req_valid = 1'b1; req_op = SEQ_ADD; req_a = 16'h1234; req_b = 16'h4321;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_ctrl_hi", alu_ctrl, ALU_ADD);
    chk("pre_rst_alu_a_hi", alu_a, 8'h12);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      chk("midrst_no_rsp", seen, 0);
    end

    // Random ops against the model.
    for (int n = 0; n < 40; n++) begin
      do_op(SEQ_OP'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq16.md
# alu_seq16

16-bit operation sequencer that drives the shared 8-bit ALU over several cycles to produce 16-bit ADD, SUB, AND and OR results.
- The ALU has no carry-out, so the block derives carry/borrow itself with an `ALU_LT` pass and folds it into the high byte.
- It sits between the instruction control path (request side) and the ALU (control/operand side). It owns the ALU for the whole operation and has a valid/ready handshake on both request and response.

## Interface
Parameters: none (widths fixed at 8-bit ALU, 16-bit operands).

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_op`  in  2  `SEQ_OP`: `SEQ_ADD`, `SEQ_SUB`, `SEQ_AND`, `SEQ_OR`
- `req_a`  in  16  operand A
- `req_b`  in  16  operand B
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes result
- `rsp_result`  out  16  16-bit result
- `rsp_zero`  out  1  `rsp_result == 0`
- `alu_ctrl`  out  `ALU_CTRL`  ALU operation select
- `alu_a`  out  8  ALU operand a
- `alu_b`  out  8  ALU operand b
- `alu_out`  in  8  ALU combinational result, same cycle

## Operation
States: `IDLE`, `LO`, `CY`, `HI`, `HC`, `DONE`.

- **IDLE**
  - `req_ready`=1. On `req_valid`, latch op, A and B, clear carry register `cy`, then go to `LO`.
  - ALU outputs driven to `ALU_AND`, 0, 0.
- **LO**
  - ADD: `ALU_ADD`, a=A[7:0], b=B[7:0].
  - SUB: `ALU_SUB`, same operands.
  - AND/OR: `ALU_AND`/`ALU_OR`, same operands.
  - Capture `alu_out` into R[7:0].
  - Next state: `CY` for ADD/SUB, `HI` for AND/OR.
- **CY**
  - ADD: `ALU_LT`, a=R[7:0], b=A[7:0] (carry = sum < A).
  - SUB: `ALU_LT`, a=A[7:0], b=B[7:0] (borrow).
  - `cy` ← `alu_out[0]`. Next state: `HI`.
- **HI**
  - Same ALU op as `LO`, on A[15:8] and B[15:8]. Capture into R[15:8].
  - Next state: `HC` for ADD/SUB, `DONE` for AND/OR.
- **HC**
  - ADD: `ALU_ADD`; SUB: `ALU_SUB`. a=R[15:8], b={7'b0,cy}.
  - R[15:8] ← `alu_out`. Next state: `DONE`.
- **DONE**
  - `rsp_valid`=1; `rsp_result`=R and `rsp_zero` held stable.
  - On `rsp_ready`, go to `IDLE`. No new request is accepted in the same cycle.

Arithmetic rules:
- Results are modulo 2^16. Carry/borrow out of bit 15 is discarded.
- `rsp_zero` is computed from the registered R, not from the ALU `zero` output.

## Timing
- Reset values: state=`IDLE`, `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=1, `cy`=0, `alu_ctrl`=`ALU_AND`, `alu_a`=0, `alu_b`=0.
- ALU outputs are combinational from state and latched operands. `alu_out` is sampled at the end of the same cycle.
- Latency, counted as edges from the accept edge to the edge that raises `rsp_valid`:
  - ADD/SUB: 5
  - AND/OR: 3
- Throughput:
  - ADD/SUB: one op per 6 cycles minimum.
  - AND/OR: one op per 4 cycles minimum.
- Backpressure: `rsp_valid` stays high and `rsp_result` is frozen indefinitely while `rsp_ready`=0.
- `req_valid` outside `IDLE` is ignored. The requester must hold its request until it sees `req_ready`.
- Reset asserted in any state: on the next edge, go to `IDLE`. The in-flight op is abandoned and no response is produced.

## Configuration
- `ALU_SEQ_SKIP_EN` defined:
  - ADD/SUB go from `HI` straight to `DONE` when `cy`=0, saving one cycle (latency 4).
  - When `cy`=1, `HC` is still used (latency 5).
- Undefined: `HC` always executes, giving fixed latency.

## Structure
- Package `alu_seq_def`:
  - `SEQ_OP` enum (2-bit: ADD=0, SUB=1, AND=2, OR=3)
  - `SEQ_STATE` enum
- `ALU_CTRL` and its encodings are imported from `ALU_def`.
- No sub-module. The ALU is instantiated by the parent and wired to `alu_*`, so it can be shared or muxed there.

## Test plan
- ADD 0x12FF + 0x0001 → `rsp_result`=0x1300, `rsp_zero`=0, `rsp_valid` 5 edges after accept. `alu_ctrl` sequence: ADD, LT, ADD, ADD.
- SUB 0x1000 − 0x0001 → 0x0FFF. `cy`=1 after `CY`; `HC` drives `ALU_SUB` with b=0x01.
- ADD 0xFFFF + 0x0001 → 0x0000, `rsp_zero`=1 (wrap-around).
- AND 0xF0F0 & 0x3C3C → 0x3030 in 3 edges. OR 0x00F0 | 0x0F00 → 0x0FF0. Neither passes through `CY`/`HC`.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 10 cycles: result and valid stay stable, `req_ready`=0 throughout.
  - Reset asserted during `HI`: `rsp_valid` never rises, `req_ready`=1 on the next edge.
- With `ALU_SEQ_SKIP_EN`: ADD 0x0101 + 0x0101 → 0x0202 with latency 4. ADD 0x00FF + 0x0001 → 0x0100 with latency 5.
